// File: rtl/tx_arbiter.sv
// Two-requester round-robin front end for a shared packet_sender.
// Latches the winner's packet, launches it, then tracks the sender's busy handshake.
module tx_arbiter #(
    parameter int PACKET_SIZE  = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     hwclk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [8*PACKET_SIZE-1:0] pkt0,
    input  logic [8*PACKET_SIZE-1:0] pkt1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     done0,
    output logic                     done1,
    output logic [8*PACKET_SIZE-1:0] tx_packet,
    output logic                     tx_enable,
    input  logic                     tx_busy,
    output logic                     err_timeout,
    output logic                     active
);
    localparam int W     = 8 * PACKET_SIZE;
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       done_reg, done_next;
    logic             tx_enable_reg, tx_enable_next;
    logic             err_reg, err_next;
    logic             active_reg, active_next;
    logic [W-1:0]     tx_packet_reg, tx_packet_next;

    logic [1:0]       req_vec;
    logic [W-1:0]     pkt_arr [2];
    logic             win;
    logic             launch;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_vec[gi] = (gi == 0) ? req0 : req1;
            assign pkt_arr[gi] = (gi == 0) ? pkt0 : pkt1;
        end
    endgenerate

    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign win    = req_vec[1] && (!req_vec[0] || !last_reg);
    assign launch = (state_reg == IDLE) && !tx_busy && (|req_vec);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            gnt_reg       <= '0;
            done_reg      <= '0;
            tx_enable_reg <= 1'b0;
            err_reg       <= 1'b0;
            active_reg    <= 1'b0;
            tx_packet_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            tx_enable_reg <= tx_enable_next;
            err_reg       <= err_next;
            active_reg    <= active_next;
            tx_packet_reg <= tx_packet_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    state_next = WAIT_HI;
                    cnt_next   = '0;
                    owner_next = win;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            WAIT_LO: begin
                // Fairness pointer only moves on a completed transfer, never on timeout.
                if (!tx_busy) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next       = '0;
        done_next      = '0;
        tx_enable_next = launch;
        err_next       = (state_reg == WAIT_HI) && !tx_busy && (cnt_reg == CNT_LAST);
        active_next    = (state_next != IDLE);
        tx_packet_next = launch ? pkt_arr[win] : tx_packet_reg;
        for (int i = 0; i < 2; i++) begin
            gnt_next[i]  = launch && (win == i[0]);
            done_next[i] = (state_reg == WAIT_LO) && !tx_busy && (owner_reg == i[0]);
        end
    end

    assign gnt0        = gnt_reg[0];
    assign gnt1        = gnt_reg[1];
    assign done0       = done_reg[0];
    assign done1       = done_reg[1];
    assign tx_enable   = tx_enable_reg;
    assign err_timeout = err_reg;
    assign active      = active_reg;
    assign tx_packet   = tx_packet_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: fixed vector table, directed corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_tx_arbiter;
    localparam int T = 4;

    logic        hwclk = 1'b0;
    logic        rst, req0, req1, tx_busy;
    logic [15:0] pkt0, pkt1;
    logic        gnt0, gnt1, done0, done1, tx_enable, err_timeout, active;
    logic [15:0] tx_packet;

    int vectors     = 0;
    int miscompares = 0;

    tx_arbiter #(.PACKET_SIZE(2), .BUSY_TIMEOUT(T)) dut (
        .hwclk(hwclk), .rst(rst), .req0(req0), .req1(req1),
        .pkt0(pkt0), .pkt1(pkt1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .tx_packet(tx_packet),
        .tx_enable(tx_enable), .tx_busy(tx_busy),
        .err_timeout(err_timeout), .active(active)
    );

    always #5 hwclk = ~hwclk;

    // Reference model: one outstanding transaction, identified by its owner.
    int          m_owner = -1;
    bit          m_seen  = 0;
    int          m_age   = 0;
    int          m_last  = 1;
    logic [15:0] m_pkt   = '0;
    logic [6:0]  m_out   = '0;   // {gnt0,gnt1,tx_enable,done0,done1,err_timeout,active}

    task automatic model_edge(input logic r, input logic a, input logic b,
                              input logic bz, input logic [15:0] p0, input logic [15:0] p1);
        int w;
        m_out = '0;
        if (r) begin
            m_owner = -1; m_last = 1; m_pkt = '0; m_seen = 0; m_age = 0;
        end else if (m_owner < 0) begin
            if (!bz && (a || b)) begin
                w = (a && b) ? (1 - m_last) : (b ? 1 : 0);
                m_owner = w; m_seen = 0; m_age = 0;
                m_pkt = (w == 1) ? p1 : p0;
                m_out[6 - w] = 1'b1;
                m_out[4] = 1'b1;
            end
        end else if (!m_seen) begin
            if (bz) m_seen = 1;
            else begin
                m_age++;
                if (m_age >= T) begin
                    m_out[1] = 1'b1;
                    m_owner = -1;
                end
            end
        end else if (!bz) begin
            m_out[3 - m_owner] = 1'b1;
            m_last = m_owner;
            m_owner = -1;
        end
        m_out[0] = (m_owner >= 0);
    endtask

    function automatic logic [6:0] outs();
        return {gnt0, gnt1, tx_enable, done0, done1, err_timeout, active};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic step(input logic r, input logic a, input logic b, input logic bz);
        rst = r; req0 = a; req1 = b; tx_busy = bz;
        @(posedge hwclk);
        #1;
        model_edge(r, a, b, bz, pkt0, pkt1);
        vectors++;
        if (outs() !== m_out || tx_packet !== m_pkt) begin
            miscompares++;
            $display("FAIL model t=%0t: outs=%b pkt=%h expected outs=%b pkt=%h",
                     $time, outs(), tx_packet, m_out, m_pkt);
        end
    endtask

    typedef struct {
        logic [3:0]  in;    // {rst, req0, req1, tx_busy}
        logic [6:0]  exp;
        logic [15:0] pkt;
    } vec_t;

    vec_t tbl [18];
    int   gnt1_seen;
    logic a_r, b_r, bz_r;

    initial begin
        tbl[0]  = '{4'b1000, 7'b0000000, 16'h0000};
        tbl[1]  = '{4'b0100, 7'b1010001, 16'h6162};
        tbl[2]  = '{4'b0000, 7'b0000001, 16'h6162};
        tbl[3]  = '{4'b0001, 7'b0000001, 16'h6162};
        tbl[4]  = '{4'b0001, 7'b0000001, 16'h6162};
        tbl[5]  = '{4'b0000, 7'b0001000, 16'h6162};
        tbl[6]  = '{4'b0110, 7'b0110001, 16'h7a7a};
        tbl[7]  = '{4'b0101, 7'b0000001, 16'h7a7a};
        tbl[8]  = '{4'b0100, 7'b0000100, 16'h7a7a};
        tbl[9]  = '{4'b0110, 7'b1010001, 16'h6162};
        tbl[10] = '{4'b0010, 7'b0000001, 16'h6162};
        tbl[11] = '{4'b0010, 7'b0000001, 16'h6162};
        tbl[12] = '{4'b0010, 7'b0000001, 16'h6162};
        tbl[13] = '{4'b0010, 7'b0000010, 16'h6162};
        tbl[14] = '{4'b0110, 7'b1010001, 16'h6162};
        tbl[15] = '{4'b0011, 7'b0000001, 16'h6162};
        tbl[16] = '{4'b0010, 7'b0001000, 16'h6162};
        tbl[17] = '{4'b0010, 7'b0110001, 16'h7a7a};

        pkt0 = 16'h6162;
        pkt1 = 16'h7a7a;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("table[%0d]", i), {9'd0, outs(), tx_packet}, {9'd0, tbl[i].exp, tbl[i].pkt});
        end

        // Busy held across reset release blocks the waiting requester 1.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            chk("busy_block_no_gnt", {30'd0, gnt1, active}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("busy_block_gnt1", {31'd0, gnt1}, 32'd1);

        // Reset while the sender is busy aborts without done and blocks regrant.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_active", {31'd0, active}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {9'd0, outs(), tx_packet}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            chk("rst_busy_hold", {29'd0, gnt0, done0, active}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_regrant_gnt0", {30'd0, gnt0, tx_enable}, 32'd3);

        // A one-cycle req1 pulse during WAIT_LO is a withdrawal.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        gnt1_seen = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        gnt1_seen += int'(gnt1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        gnt1_seen += int'(gnt1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("withdraw_done0", {31'd0, done0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            gnt1_seen += int'(gnt1);
        end
        chk("withdraw_no_gnt1", gnt1_seen, 32'd0);

        // Randomized traffic against the model.
        a_r = 1'b0; b_r = 1'b0; bz_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) a_r = ~a_r;
            if ($urandom_range(0, 3) == 0) b_r = ~b_r;
            if ($urandom_range(0, 3) == 0) bz_r = ~bz_r;
            pkt0 = 16'($urandom);
            pkt1 = 16'($urandom);
            step(($urandom_range(0, 99) == 0), a_r, b_r, bz_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
